// File: rtl/cpu_shift_pkg.sv
// Shared op codes and FSM state encoding for the shift/rotate execution unit.
package cpu_shift_pkg;

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value_i by s_i (0..STEP) positions
// according to op_i; unknown op codes pass the value through untouched.
module shift_step
    import cpu_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [2:0]       op_i,
    input  logic [SW-1:0]    s_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] value_o
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [STEP:0][WIDTH-1:0] cand;

    // One candidate per possible step size; shifts by WIDTH collapse to zero,
    // which keeps the zero-step rotate equal to the input.
    for (genvar gi = 0; gi <= STEP; gi++) begin : g_amt
        localparam logic [WIDTH-1:0] FILL = ~(ONES >> gi);
        assign cand[gi] =
            (op_i == OP_SHR)  ? (value_i >> gi) :
            (op_i == OP_SHRA) ? ((value_i >> gi) | (sign_i ? FILL : '0)) :
            (op_i == OP_SHL)  ? (value_i << gi) :
            (op_i == OP_ROR)  ? ((value_i >> gi) | (value_i << (WIDTH - gi))) :
            (op_i == OP_ROL)  ? ((value_i << gi) | (value_i >> (WIDTH - gi))) :
                                value_i;
    end

    always_comb begin
        value_o = value_i;
        for (int i = 0; i <= STEP; i++) begin
            if (s_i == SW'(i)) begin
                value_o = cand[i];
            end
        end
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: latches the operand on start, then shifts up to
// STEP positions per cycle until the effective count is exhausted.
module shift_rotate_unit
    import cpu_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] amt,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int LOG_W = $clog2(WIDTH);
    localparam int SW    = $clog2(STEP + 1);

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q;

    logic [CNT_W-1:0] load_cnt;
    logic [SW-1:0]    s;
    logic [WIDTH-1:0] stepped;
    logic             accept;

    // Shifts saturate at WIDTH; rotates only care about the amount modulo WIDTH.
    always_comb begin
        load_cnt = '0;
        case (op)
            OP_SHR, OP_SHRA, OP_SHL:
                load_cnt = (amt >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(amt);
            OP_ROR, OP_ROL:
                load_cnt = CNT_W'(amt[LOG_W-1:0]);
            default:
                load_cnt = '0;
        endcase
    end

    assign s      = (cnt_q > CNT_W'(STEP)) ? SW'(STEP) : SW'(cnt_q);
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SW    (SW)
    ) u_step (
        .value_i (result_q),
        .op_i    (op_q),
        .s_i     (s),
        .sign_i  (sign_q),
        .value_o (stepped)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            result_q <= '0;
            op_q     <= OP_SHR;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            case (state_q)
                SHIFT: begin
                    result_q <= stepped;
                    cnt_q    <= cnt_q - CNT_W'(s);
                    if (cnt_q <= CNT_W'(STEP)) begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        result_q <= a;
                        op_q     <= op;
                        sign_q   <= a[WIDTH-1];
                        cnt_q    <= load_cnt;
                        state_q  <= (load_cnt != '0) ? SHIFT : DONE;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign result = result_q;
    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Randomised and directed checks of shift_rotate_unit against a cycle-count
// reference model, plus a STEP=1 instance for the single-position variant.
module tb_shift_rotate_unit;
    import cpu_shift_pkg::*;

    localparam int W      = 32;
    localparam int TSTEP  = 4;

    logic          clk = 1'b0;
    logic          clr, start;
    logic [2:0]    op;
    logic [W-1:0]  a, amt, result;
    logic          busy, done;

    logic          s1_clr, s1_start;
    logic [2:0]    s1_op;
    logic [W-1:0]  s1_a, s1_amt, s1_result;
    logic          s1_busy, s1_done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_out  = '0;
    logic [31:0] m_final = '0;

    always #5 clk = ~clk;

    shift_rotate_unit #(.WIDTH(W), .STEP(TSTEP)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .amt(amt),
        .result(result), .busy(busy), .done(done)
    );

    shift_rotate_unit #(.WIDTH(W), .STEP(1)) dut1 (
        .clk(clk), .clr(s1_clr), .start(s1_start), .op(s1_op), .a(s1_a), .amt(s1_amt),
        .result(s1_result), .busy(s1_busy), .done(s1_done)
    );

    function automatic logic [31:0] ref_res(logic [2:0] o, logic [31:0] av, logic [31:0] amv);
        logic [63:0] t;
        int c;
        int r;
        c = (amv >= 32) ? 32 : int'(amv);
        r = int'(amv % 32);
        case (o)
            3'd0: begin t = {32'b0, av} >> c;          return t[31:0];  end
            3'd1: begin t = {{32{av[31]}}, av} >> c;   return t[31:0];  end
            3'd2: begin t = {32'b0, av} << c;          return t[31:0];  end
            3'd3: begin t = {av, av} >> r;             return t[31:0];  end
            3'd4: begin t = {av, av} << r;             return t[63:32]; end
            default: return av;
        endcase
    endfunction

    function automatic int ref_n(logic [2:0] o, logic [31:0] amv, int stp);
        int c;
        case (o)
            3'd0, 3'd1, 3'd2: c = (amv >= 32) ? 32 : int'(amv);
            3'd3, 3'd4:       c = int'(amv % 32);
            default:          c = 0;
        endcase
        return (c + stp - 1) / stp;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: cycles of SHIFT left, then one DONE cycle with the final value.
    always @(posedge clk) begin
        if (clr) begin
            m_left = 0;
            m_done = 1'b0;
            m_out  = '0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_left == 0) m_out = m_final;
        end else if (start) begin
            m_final = ref_res(op, a, amt);
            m_left  = ref_n(op, amt, TSTEP);
            m_done  = (m_left == 0);
            if (m_left == 0) m_out = m_final;
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model busy", {31'b0, busy}, {31'b0, m_left > 0});
            chk("model done", {31'b0, done}, {31'b0, m_done});
            if (m_left == 0) chk("model result", result, m_out);
        end
    end

    task automatic run_op(input string tag, input bit imm, input logic [2:0] o,
                          input logic [31:0] av, input logic [31:0] amv,
                          input logic [31:0] ex_res, input int ex_lat);
        int lat;
        if (!imm) @(negedge clk);
        start = 1'b1; op = o; a = av; amt = amv;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; amt = $urandom;
            lat++;
        end while (!done && lat < 100);
        chk({tag, " latency"}, 32'(lat), 32'(ex_lat));
        chk({tag, " result"}, result, ex_res);
        $display("op %s: a=%h amt=%0d result=%h latency=%0d", tag, av, amv, result, lat);
    endtask

    initial begin
        int lat;
        int busyc;
        int seen;
        clr = 1'b1; start = 1'b0; op = '0; a = '0; amt = '0;
        s1_clr = 1'b1; s1_start = 1'b0; s1_op = '0; s1_a = '0; s1_amt = '0;
        repeat (2) @(negedge clk);
        chk("reset result", result, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset done", {31'b0, done}, 32'h0);
        chk_en = 1'b1;
        clr = 1'b0; s1_clr = 1'b0;

        // hand-computed pins of both model and DUT
        chk("pin ref SHRA", ref_res(OP_SHRA, 32'h80000000, 32'd4), 32'hF8000000);
        chk("pin ref ROL", ref_res(OP_ROL, 32'h80000001, 32'd36), 32'h00000018);
        run_op("SHR2",     1'b0, OP_SHR,  32'h00000018, 32'd2,   32'h00000006, 2);
        run_op("SHRA4",    1'b0, OP_SHRA, 32'h80000000, 32'd4,   32'hF8000000, 2);
        run_op("SHRA100",  1'b0, OP_SHRA, 32'h80000000, 32'd100, 32'hFFFFFFFF, 9);
        run_op("ROL36",    1'b0, OP_ROL,  32'h80000001, 32'd36,  32'h00000018, 2);
        run_op("ROR32",    1'b0, OP_ROR,  32'h80000001, 32'd32,  32'h80000001, 1);
        run_op("SHL40",    1'b0, OP_SHL,  32'h00000003, 32'd40,  32'h00000000, 9);
        run_op("PASS7",    1'b0, 3'd7,    32'hDEADBEEF, 32'd9,   32'hDEADBEEF, 1);
        run_op("ROR7",     1'b0, OP_ROR,  32'h0000000F, 32'd7,   32'h1E000000, 3);
        // back-to-back: accepted in the DONE cycle of the previous op
        run_op("B2B",      1'b1, OP_SHL,  32'h00000001, 32'd31,  32'h80000000, 9);

        // start pulsed during SHIFT is ignored
        @(negedge clk);
        start = 1'b1; op = OP_SHRA; a = 32'h80000000; amt = 32'd100;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == 3);
            op = OP_SHL; a = 32'h0; amt = 32'h0;
        end while (!done && lat < 100);
        start = 1'b0;
        chk("ignore-start latency", 32'(lat), 32'd9);
        chk("ignore-start result", result, 32'hFFFFFFFF);
        $display("op ignore-start: result=%h latency=%0d", result, lat);

        // clr mid-SHIFT discards the partial result
        @(negedge clk);
        start = 1'b1; op = OP_SHL; a = 32'h00000001; amt = 32'd20;
        @(negedge clk); start = 1'b0;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("clr busy", {31'b0, busy}, 32'h0);
        chk("clr result", result, 32'h0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("clr no done", 32'(seen), 32'h0);
        $display("op clr-mid-shift: result=%h", result);

        // STEP=1 variant
        @(negedge clk);
        s1_start = 1'b1; s1_op = OP_SHL; s1_a = 32'h3; s1_amt = 32'd5;
        lat = 0; busyc = 0;
        do begin
            @(negedge clk);
            s1_start = 1'b0;
            lat++;
            if (s1_busy) busyc++;
        end while (!s1_done && lat < 100);
        chk("step1 busy cycles", 32'(busyc), 32'd5);
        chk("step1 latency", 32'(lat), 32'd6);
        chk("step1 result", s1_result, 32'h60);
        $display("op step1 SHL5: result=%h busy=%0d", s1_result, busyc);

        // randomised traffic, checked every cycle by the model compare
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            op    = 3'($urandom_range(0, 7));
            a     = $urandom;
            amt   = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
            clr   = ($urandom_range(0, 99) == 0);
            if (start && m_left == 0 && !clr)
                $display("rand %0d: op=%0d a=%h amt=%h expect=%h", i, op, a, amt, ref_res(op, a, amt));
        end
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_rotate_unit.md
Name: shift_rotate_unit

Overview:
- Parametrised, multi-cycle shift/rotate execution unit for the CPU datapath.
- Supersedes the single-cycle SHR path in the ALU. Adds arithmetic shift, left shift, both rotates, and a configurable number of bit positions per cycle.
- Takes operand A from the bus (Y side) and the shift amount from the bus. Produces a registered result that feeds the Z-low path.
- Uses a start/busy/done handshake so the control unit holds its T-step until done.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, minimum 8.
- STEP, 4, maximum bit positions shifted per cycle; power of two, 1 to WIDTH.
- CNT_W, $clog2(WIDTH)+1, width of the internal remaining-count register.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  3  operation code (encodings in package).
- a  in  WIDTH  operand to shift.
- amt  in  WIDTH  shift amount, unsigned.
- result  out  WIDTH  registered result.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse when result is valid.

Behaviour:
- Reset: clr at a rising edge forces state=IDLE, result=0, busy=0, done=0, internal count=0. This holds from any state, including mid-SHIFT; a partial result is discarded.
- States: IDLE, SHIFT, DONE.
- Effective count cnt:
  - SHR/SHL: min(amt, WIDTH).
  - SHRA: min(amt, WIDTH).
  - ROR/ROL: amt mod WIDTH, i.e. the low $clog2(WIDTH) bits.
  - Undefined op codes: cnt=0 and result=a (pass-through).
- Start accepted (state IDLE or DONE, start=1) at edge E0:
  - Latch a into result, latch op, load cnt.
  - Next state is SHIFT if cnt>0, else DONE.
- SHIFT, each edge:
  - Shift result by s=min(STEP, remaining), then remaining -= s.
  - When remaining reaches 0 on this edge, next state is DONE.
  - Shift cycles n = ceil(cnt/STEP).
  - done goes high in the cycle after E0+n.
  - Total latency from start to done is n+1 edges, minimum 1.
- Fill rules:
  - SHR and SHL fill with 0.
  - SHRA fills with the sign bit of the original a.
  - With cnt=WIDTH: SHR/SHL give 0; SHRA gives all sign bits.
- DONE:
  - done=1 for exactly one cycle; result holds.
  - Next state is IDLE, or SHIFT/DONE if a new start is accepted on that edge (back-to-back).
- IDLE: result holds its last value indefinitely.
- start during SHIFT is ignored (no queueing). op, a and amt may change freely after E0.
- busy = (state==SHIFT). done = (state==DONE). Both are decoded from registered state only.

Decomposition:
- Package cpu_shift_pkg holds:
  - op codes: OP_SHR=3'd0, OP_SHRA=3'd1, OP_SHL=3'd2, OP_ROR=3'd3, OP_ROL=3'd4; 5–7 are pass-through.
  - State enum values IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
- Sub-module shift_step: purely combinational, parameters WIDTH and STEP.
  - Inputs: value, op, s (0..STEP), sign bit.
  - Output: value shifted or rotated by s.
  - The top level holds the FSM, count and result registers.

Test Plan (WIDTH=32, STEP=4 unless stated):
- SHR, a=0x00000018, amt=2 → n=1; done one cycle after the first SHIFT edge; result=0x00000006.
- SHRA, a=0x80000000, amt=4 → result=0xF8000000. SHRA a=0x80000000, amt=100 → result=0xFFFFFFFF after 8 shift cycles.
- ROL, a=0x80000001, amt=36 → cnt=4, result=0x00000018. ROR same a, amt=32 → cnt=0, done at E0+1, result=0x80000001.
- SHL, a=0x00000003, amt=40 → result=0x00000000.
- STEP=1 variant: SHL, amt=5 → busy high exactly 5 cycles, result=0x60.
- Handshake corners:
  - start pulsed during SHIFT → ignored; the original op completes unchanged.
  - start asserted in the DONE cycle → the new op is accepted, with no idle gap.
  - clr asserted mid-SHIFT → next cycle state=IDLE, result=0, busy=0, done never pulses.
